// File: rtl/pixel_reorder_buffer.sv
// Reorder window between the shader's pixel-buffer port and the frame-buffer writer.
// Pixels arrive in any order inside a DEPTH-wide window and leave strictly in pixelID order.
module pixel_reorder_buffer #(
    parameter int DEPTH      = 64,
    parameter int PIX_W      = 19,
    parameter int COLOR_W    = 24,
    parameter int NUM_PIXELS = 307200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pb_we,
    input  logic [PIX_W+COLOR_W-1:0] pb_data_in,
    output logic                     pb_full,
    output logic                     out_valid,
    output logic [PIX_W-1:0]         out_pixelID,
    output logic [COLOR_W-1:0]       out_color,
    input  logic                     out_stall,
    output logic                     frame_done,
    output logic                     err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [PIX_W:0]   NUM_PIX_X = (PIX_W+1)'(NUM_PIXELS);
    localparam logic [PIX_W:0]   DEPTH_X   = (PIX_W+1)'(DEPTH);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIXELS - 1);

    logic [PIX_W-1:0]   head;
    logic [DEPTH-1:0]   valid;
    logic [OCC_W-1:0]   occ;
    logic [COLOR_W-1:0] mem [DEPTH];

    logic [PIX_W-1:0]   pid_p0;
    logic [COLOR_W-1:0] color_p0;
    logic [IDX_W-1:0]   wr_slot_p0;
    logic [IDX_W-1:0]   head_slot;
    logic               in_range_p0;
    logic               in_window_p0;
    logic               wr_ok_p0;
    logic               drain;

    // Distance ahead of head, modulo the frame, so the next frame's first pixels fit the window.
    function automatic logic [PIX_W:0] window_offset(input logic [PIX_W-1:0] pid,
                                                     input logic [PIX_W-1:0] hd);
        if (pid >= hd) window_offset = {1'b0, pid} - {1'b0, hd};
        else           window_offset = {1'b0, pid} + NUM_PIX_X - {1'b0, hd};
    endfunction

    function automatic logic [PIX_W-1:0] next_head(input logic [PIX_W-1:0] hd);
        next_head = (hd == LAST_PIX) ? '0 : hd + PIX_W'(1);
    endfunction

    // Stage 0: write decode against registered window state
    assign pid_p0       = pb_data_in[PIX_W+COLOR_W-1 -: PIX_W];
    assign color_p0     = pb_data_in[COLOR_W-1:0];
    assign wr_slot_p0   = pid_p0[IDX_W-1:0];
    assign head_slot    = head[IDX_W-1:0];
    assign in_range_p0  = {1'b0, pid_p0} < NUM_PIX_X;
    assign in_window_p0 = window_offset(pid_p0, head) < DEPTH_X;
    assign pb_full      = (occ == OCC_W'(DEPTH));
    assign wr_ok_p0     = pb_we && in_range_p0 && in_window_p0 && !pb_full && !valid[wr_slot_p0];
    assign drain        = (!out_valid || !out_stall) && valid[head_slot];

    always_ff @(posedge clk) begin
        if (wr_ok_p0) mem[wr_slot_p0] <= color_p0;
    end

    // A legal write can only target the head slot when it is empty, so set and clear never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            valid <= '0;
            occ   <= '0;
            err   <= 1'b0;
        end else begin
            if (drain) begin
                valid[head_slot] <= 1'b0;
                head             <= next_head(head);
            end
            if (wr_ok_p0) valid[wr_slot_p0] <= 1'b1;
            if (pb_we && !wr_ok_p0) err <= 1'b1;
            occ <= occ + OCC_W'(wr_ok_p0) - OCC_W'(drain);
        end
    end

    // Stage 1: output register, held while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pixelID <= '0;
            out_color   <= '0;
        end else if (drain) begin
            out_valid   <= 1'b1;
            out_pixelID <= head;
            out_color   <= mem[head_slot];
        end else if (!out_stall) begin
            out_valid   <= 1'b0;
        end
    end

    assign frame_done = out_valid && !out_stall && (out_pixelID == LAST_PIX);

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// Randomized and directed bench for pixel_reorder_buffer against a pixelID-keyed reference model.
// A reduced frame length keeps the frame-wrap scenarios within a short run.
module tb_pixel_reorder_buffer;
    localparam int DEPTH   = 64;
    localparam int PIX_W   = 19;
    localparam int COLOR_W = 24;
    localparam int NUM     = 256;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     pb_we = 1'b0;
    logic [PIX_W+COLOR_W-1:0] pb_data_in = '0;
    logic                     out_stall = 1'b0;
    logic                     pb_full;
    logic                     out_valid;
    logic [PIX_W-1:0]         out_pixelID;
    logic [COLOR_W-1:0]       out_color;
    logic                     frame_done;
    logic                     err;

    pixel_reorder_buffer #(
        .DEPTH(DEPTH), .PIX_W(PIX_W), .COLOR_W(COLOR_W), .NUM_PIXELS(NUM)
    ) dut (
        .clk(clk), .rst(rst), .pb_we(pb_we), .pb_data_in(pb_data_in), .pb_full(pb_full),
        .out_valid(out_valid), .out_pixelID(out_pixelID), .out_color(out_color),
        .out_stall(out_stall), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pixels held keyed by pixelID, next expected pixel, output register.
    logic [COLOR_W-1:0] held [int];
    int                 m_head;
    bit                 m_ov;
    int                 m_opid;
    logic [COLOR_W-1:0] m_ocol;
    bit                 m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        m_head = 0;
        m_ov   = 0;
        m_opid = 0;
        m_ocol = '0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit we, input int pid, input logic [COLOR_W-1:0] col,
                              input bit stall);
        bit full, drn, accept;
        int off;
        full   = (held.num() == DEPTH);
        drn    = (!m_ov || !stall) && held.exists(m_head);
        off    = (pid >= m_head) ? pid - m_head : pid + NUM - m_head;
        accept = we && (pid < NUM) && (off < DEPTH) && !full && !held.exists(pid);
        if (we && !accept) m_err = 1;
        if (drn) begin
            m_ov   = 1;
            m_opid = m_head;
            m_ocol = held[m_head];
            held.delete(m_head);
            m_head = (m_head + 1) % NUM;
        end else if (!stall) begin
            m_ov = 0;
        end
        if (accept) held[pid] = col;
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_pixelID", 32'(out_pixelID), 32'(m_opid));
        check("out_color", 32'(out_color), 32'(m_ocol));
        check("pb_full", 32'(pb_full), 32'(held.num() == DEPTH));
        check("frame_done", 32'(frame_done), 32'(m_ov && !out_stall && m_opid == NUM - 1));
        check("err", 32'(err), 32'(m_err));
    endtask

    // Called at a falling edge; drives one cycle's inputs and checks the settled outputs.
    task automatic cycle(input bit we, input int pid, input logic [COLOR_W-1:0] col,
                         input bit stall);
        pb_we      = we;
        pb_data_in = {PIX_W'(pid), col};
        out_stall  = stall;
        #1;
        compare_all();
        model_step(we, pid, col, stall);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit stall);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, stall);
    endtask

    task automatic do_reset();
        pb_we = 1'b0;
        out_stall = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1 compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // In order, no stall
        for (int i = 0; i < 128; i++) cycle(1'b1, i, 24'($urandom()), 1'b0);
        idle(4, 1'b0);
        do_reset();

        // Reverse order inside the window while stalled
        for (int i = 63; i >= 0; i--) cycle(1'b1, i, 24'($urandom()), 1'b1);
        idle(3, 1'b1);
        idle(70, 1'b0);
        do_reset();

        // Fill to full under stall, then overflow and duplicate writes
        for (int i = 0; i <= 64; i++) cycle(1'b1, i, 24'($urandom()), 1'b1);
        idle(2, 1'b1);
        cycle(1'b1, 65, 24'h123456, 1'b1);
        cycle(1'b1, 10, 24'h654321, 1'b1);
        idle(2, 1'b1);
        idle(70, 1'b0);
        do_reset();

        // Out-of-window and out-of-frame writes
        cycle(1'b1, 64, 24'hABCDEF, 1'b0);
        idle(3, 1'b0);
        do_reset();
        cycle(1'b1, 300, 24'hABCDEF, 1'b0);
        idle(2, 1'b0);
        do_reset();

        // Duplicate: first color must win
        cycle(1'b1, 5, 24'h111111, 1'b0);
        cycle(1'b1, 5, 24'h222222, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, i, 24'($urandom()), 1'b0);
        idle(8, 1'b0);
        do_reset();

        // Frame wrap with the last pixel delayed past the first pixels of the next frame
        for (int i = 0; i < NUM - 10; i++) cycle(1'b1, i, 24'($urandom()), 1'b0);
        for (int i = NUM - 10; i < NUM - 1; i++) cycle(1'b1, i, 24'($urandom()), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, i, 24'($urandom()), 1'b0);
        cycle(1'b1, NUM - 1, 24'($urandom()), 1'b0);
        for (int i = 4; i < 10; i++) cycle(1'b1, i, 24'($urandom()), 1'b0);
        idle(12, 1'b0);
        do_reset();

        // Random completion order with random backpressure
        for (int n = 0; n < 2000; n++) begin
            bit we;
            int pid;
            we  = ($urandom() % 4) != 0;
            pid = (m_head + int'($urandom_range(0, DEPTH - 1))) % NUM;
            if ($urandom() % 50 == 0) pid = int'($urandom_range(0, 511));
            if ((held.exists(pid) || held.num() == DEPTH) && ($urandom() % 20 != 0)) we = 0;
            cycle(we, pid, 24'($urandom()), ($urandom() % 3) == 0);
        end
        idle(80, 1'b0);
        do_reset();

        // Asynchronous reset while pixels are held and the output is valid
        for (int i = 0; i <= 20; i++) cycle(1'b1, i, 24'($urandom()), 1'b1);
        idle(2, 1'b1);
        check("held_before_rst", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pixelID", 32'(out_pixelID), 32'd0);
        check("rst_out_color", 32'(out_color), 32'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        out_stall = 1'b0;
        cycle(1'b1, 0, 24'h0F0F0F, 1'b0);
        cycle(1'b0, 0, '0, 1'b0);
        check("rst_pix0_valid", 32'(out_valid), 32'd1);
        check("rst_pix0_id", 32'(out_pixelID), 32'd0);
        check("rst_pix0_color", 32'(out_color), 32'h0F0F0F);
        idle(3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
